vend_controller: RTL and testbench
==================================

// Module: vend_controller
// PURPOSE
//  Top-level sequencer for the coin vending datapath. Accepts coin events,
//  accumulates credit and validates product selection against a price table.
//  Runs a req/ack dispense handshake with the motor driver, then pays change
//  one coin at a time through a req/ack payout channel. Sits between the coin
//  acceptor/keypad front end and the dispense/payout actuators.
// PARAMETERS
//  NUM_ITEMS   4                  number of selectable products (1..8)
//  CREDIT_W    6                  credit register width, units of 5c
//  MAX_CREDIT  40                 credit ceiling in units; must be < 2**CREDIT_W
//  PRICES      {6'd5,6'd4,6'd3,6'd2}  packed price table, item0 in LSBs, units of 5c
// PORTS
//  clk        in   1         system clock, rising edge
//  rst        in   1         asynchronous, active-low reset
//  in         in   2         coin event per cycle: 00 none, 01 5c, 10 10c, 11 invalid
//  sel_valid  in   1         one-cycle product select strobe
//  sel_item   in   3         product index, sampled with sel_valid
//  cancel     in   1         one-cycle refund request
//  disp_ack   in   1         motor driver completion
//  chg_ack    in   1         payout unit accepted current coin
//  disp_req   out  1         dispense request, held until disp_ack
//  disp_item  out  3         item being dispensed, stable while disp_req
//  chg_valid  out  1         change coin request, held until chg_ack
//  chg_coin   out  2         01 = 5c, 10 = 10c; stable while chg_valid
//  coin_rej   out  1         one-cycle pulse: coin not credited
//  sel_err    out  1         one-cycle pulse: bad index or insufficient credit
//  vend_done  out  1         one-cycle pulse on disp_ack
//  credit     out  CREDIT_W  current credit, units of 5c
//  c_state    out  2         current FSM state (debug)
// BEHAVIOUR
//  Reset (rst=0): state IDLE, credit 0, all outputs 0; credit in flight is lost.
//  States: IDLE=0, CREDIT=1, DISPENSE=2, CHANGE=3. All outputs are registered.
//  Coin (IDLE/CREDIT): credit += 1 (01) or 2 (10); IDLE->CREDIT. Effect is
//   visible on credit one cycle after the coin.
//  Reject rules: coin_rej pulses and credit is unchanged if the coin is 11, or
//   the state is DISPENSE/CHANGE, or credit+coin would exceed MAX_CREDIT.
//  Same-cycle priority in CREDIT: cancel > sel_valid > coin; a losing coin is
//   rejected (coin_rej).
//  cancel in CREDIT: -> CHANGE with the full credit. cancel in IDLE: ignored.
//  sel_valid in CREDIT:
//   - sel_item >= NUM_ITEMS, or credit < price: sel_err; stay in CREDIT.
//   - otherwise: credit -= price; -> DISPENSE; disp_req=1, disp_item latched.
//   sel_valid in IDLE: sel_err.
//  DISPENSE: hold disp_req until disp_ack is sampled high. Then drop disp_req,
//   pulse vend_done, and go to CHANGE if credit>0, else IDLE. No timeout.
//  CHANGE: greedy, largest coin first. chg_coin=10 while credit>=2, else 01.
//   On each chg_ack: credit -= coin value. A new coin is presented the next
//   cycle. At credit==0: chg_valid=0, -> IDLE.
//  Handshake: disp_req/chg_valid never drop before ack. An ack seen while the
//   matching request is low is ignored.
//  Exact-price vend (credit==price): DISPENSE -> IDLE with no CHANGE state.
// CONFIGURATION
//  VEND_TIMEOUT_EN: when defined, a 16-bit idle counter runs in CREDIT. It is
//   cleared by any coin, select or cancel. At 50000 cycles it triggers an
//   automatic refund (-> CHANGE, as with cancel). When undefined, there is no
//   counter and credit is held indefinitely.
// STRUCTURE
//  vend_pkg: state enum (IDLE/CREDIT/DISPENSE/CHANGE), coin encodings
//   COIN_NONE/COIN_5/COIN_10, and the timeout constant.
//  Sub-module vend_change_payout: owns the CHANGE coin selection and the
//   chg_valid/chg_ack handshake. Interface: start, amount, and done back to
//   the main FSM.
// TESTING
//  1. Three 01 coins, sel item1 (price 4) -> sel_err; one more 01 coin, sel
//     item1 -> disp_req, credit 0. disp_ack -> vend_done, IDLE.
//  2. Coins 10,10,01 (credit 5), sel item2 (price 3) -> credit 2 -> one
//     chg_coin=10 -> IDLE, credit 0.
//  3. Credit 3, cancel -> chg_coin 10 then 01, each held until chg_ack
//     (ack delayed 4 cycles).
//  4. Coin during DISPENSE, coin 11, and coin with credit=MAX_CREDIT-1 plus
//     10 -> coin_rej each time, credit unchanged.
//  5. Same cycle sel_valid + coin 01 with credit 2, item3 -> dispense; coin
//     rejected. Also sel_item=5 -> sel_err.
//  6. rst low mid-DISPENSE and mid-CHANGE -> all outputs 0 asynchronously,
//     IDLE after release. With VEND_TIMEOUT_EN: credit 2, idle 50000
//     cycles -> refund.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the coin vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vend_state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    localparam logic [15:0] VEND_TIMEOUT = 16'd50000;

    // Credit units (5c) carried by a coin code; invalid/none carry nothing.
    function automatic logic [1:0] coin_units(input logic [1:0] coin);
        unique case (coin)
            COIN_5:  return 2'd1;
            COIN_10: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_payout.sv
// Change payout engine: greedy 10c/5c coin selection over a chg_valid/chg_ack handshake.
module vend_change_payout
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CREDIT_W-1:0] amount,
    input  logic                ack,
    output logic                valid,
    output logic [1:0]          coin,
    output logic                paid,
    output logic                done
);

    logic                valid_q, valid_d;
    logic [1:0]          coin_q, coin_d;
    logic [CREDIT_W-1:0] rem_q, rem_d, rem_after;

    function automatic logic [1:0] greedy(input logic [CREDIT_W-1:0] amt);
        return (amt >= CREDIT_W'(2)) ? COIN_10 : COIN_5;
    endfunction

    // Kept as continuous assigns so the main FSM can consume them without a block-level loop.
    assign paid      = valid_q & ack;
    assign rem_after = rem_q - CREDIT_W'(coin_units(coin_q));
    assign done      = paid && (rem_after == '0);

    always_comb begin
        valid_d = valid_q;
        coin_d  = coin_q;
        rem_d   = rem_q;
        if (start) begin
            rem_d   = amount;
            valid_d = (amount != '0);
            coin_d  = (amount != '0) ? greedy(amount) : COIN_NONE;
        end else if (paid) begin
            rem_d = rem_after;
            if (rem_after == '0) begin
                valid_d = 1'b0;
                coin_d  = COIN_NONE;
            end else begin
                coin_d = greedy(rem_after);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            coin_q  <= COIN_NONE;
            rem_q   <= '0;
        end else begin
            valid_q <= valid_d;
            coin_q  <= coin_d;
            rem_q   <= rem_d;
        end
    end

    assign valid = valid_q;
    assign coin  = coin_q;

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: credit accumulation, product select, dispense handshake, change payout.
// Optional VEND_TIMEOUT_EN adds an inactivity refund while holding credit.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned                   NUM_ITEMS  = 4,
    parameter int unsigned                   CREDIT_W   = 6,
    parameter int unsigned                   MAX_CREDIT = 40,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {6'd5, 6'd4, 6'd3, 6'd2}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          in,
    input  logic                sel_valid,
    input  logic [2:0]          sel_item,
    input  logic                cancel,
    input  logic                disp_ack,
    input  logic                chg_ack,
    output logic                disp_req,
    output logic [2:0]          disp_item,
    output logic                chg_valid,
    output logic [1:0]          chg_coin,
    output logic                coin_rej,
    output logic                sel_err,
    output logic                vend_done,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          c_state
);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                disp_req_q, disp_req_d;
    logic [2:0]          disp_item_q, disp_item_d;
    logic                coin_rej_q, coin_rej_d;
    logic                sel_err_q, sel_err_d;
    logic                vend_done_q, vend_done_d;
    logic                pay_start, pay_paid, pay_done, timeout;

    // Price table widened to the full 3-bit index space; out-of-range entries are never used.
    logic [CREDIT_W-1:0] price_tab [8];
    for (genvar i = 0; i < 8; i++) begin : g_price
        if (i < NUM_ITEMS) begin : g_used
            assign price_tab[i] = PRICES[i*CREDIT_W +: CREDIT_W];
        end else begin : g_unused
            assign price_tab[i] = '0;
        end
    end

    logic                idx_ok, coin_present, coin_ok;
    logic [CREDIT_W-1:0] price, paid_val;
    logic [CREDIT_W:0]   coin_sum;

    assign idx_ok       = {1'b0, sel_item} < 4'(NUM_ITEMS);
    assign price        = price_tab[sel_item];
    assign coin_present = (in != COIN_NONE);
    assign coin_sum     = {1'b0, credit_q} + (CREDIT_W+1)'(coin_units(in));
    assign coin_ok      = (in == COIN_5 || in == COIN_10) &&
                          (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign paid_val     = CREDIT_W'(coin_units(chg_coin));

`ifdef VEND_TIMEOUT_EN
    logic [15:0] idle_cnt_q;
    logic        activity;

    assign activity = coin_present || sel_valid || cancel;
    assign timeout  = (state_q == CREDIT) && !activity && (idle_cnt_q == VEND_TIMEOUT - 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt_q <= '0;
        end else if (state_q != CREDIT || activity || timeout) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        disp_req_d  = disp_req_q;
        disp_item_d = disp_item_q;
        coin_rej_d  = 1'b0;
        sel_err_d   = 1'b0;
        vend_done_d = 1'b0;
        pay_start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                sel_err_d = sel_valid;
                if (coin_present) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = CREDIT;
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end
            end
            CREDIT: begin
                if (cancel || timeout) begin
                    coin_rej_d = coin_present;
                    state_d    = CHANGE;
                    pay_start  = 1'b1;
                end else if (sel_valid) begin
                    coin_rej_d = coin_present;
                    if (!idx_ok || credit_q < price) begin
                        sel_err_d = 1'b1;
                    end else begin
                        credit_d    = credit_q - price;
                        state_d     = DISPENSE;
                        disp_req_d  = 1'b1;
                        disp_item_d = sel_item;
                    end
                end else if (coin_present) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                coin_rej_d = coin_present;
                if (disp_ack) begin
                    disp_req_d  = 1'b0;
                    vend_done_d = 1'b1;
                    if (credit_q != '0) begin
                        state_d   = CHANGE;
                        pay_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CHANGE: begin
                coin_rej_d = coin_present;
                if (pay_paid) credit_d = credit_q - paid_val;
                if (pay_done) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            credit_q    <= '0;
            disp_req_q  <= 1'b0;
            disp_item_q <= '0;
            coin_rej_q  <= 1'b0;
            sel_err_q   <= 1'b0;
            vend_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            disp_req_q  <= disp_req_d;
            disp_item_q <= disp_item_d;
            coin_rej_q  <= coin_rej_d;
            sel_err_q   <= sel_err_d;
            vend_done_q <= vend_done_d;
        end
    end

    vend_change_payout #(
        .CREDIT_W(CREDIT_W)
    ) u_payout (
        .clk   (clk),
        .rst   (rst),
        .start (pay_start),
        .amount(credit_q),
        .ack   (chg_ack),
        .valid (chg_valid),
        .coin  (chg_coin),
        .paid  (pay_paid),
        .done  (pay_done)
    );

    assign disp_req  = disp_req_q;
    assign disp_item = disp_item_q;
    assign coin_rej  = coin_rej_q;
    assign sel_err   = sel_err_q;
    assign vend_done = vend_done_q;
    assign credit    = credit_q;
    assign c_state   = state_q;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus randomized transactions
// checked against a transaction-level credit model.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in;
    logic       sel_valid;
    logic [2:0] sel_item;
    logic       cancel, disp_ack, chg_ack;
    logic       disp_req, chg_valid, coin_rej, sel_err, vend_done;
    logic [2:0] disp_item;
    logic [1:0] chg_coin, c_state;
    logic [5:0] credit;

    int errors = 0;
    int checks = 0;

    // Model: credit in 5c units, phase 0 idle / 1 credit / 2 dispense / 3 change.
    int m_credit, m_state, m_item;
    // Price table used by the directed scenarios: item0=5, item1=4, item2=3, item3=2.
    int price_tab[4] = '{5, 4, 3, 2};

    vend_controller #(
        .NUM_ITEMS (4),
        .CREDIT_W  (6),
        .MAX_CREDIT(40),
        .PRICES    ({6'd2, 6'd3, 6'd4, 6'd5})
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .sel_valid(sel_valid),
        .sel_item (sel_item),
        .cancel   (cancel),
        .disp_ack (disp_ack),
        .chg_ack  (chg_ack),
        .disp_req (disp_req),
        .disp_item(disp_item),
        .chg_valid(chg_valid),
        .chg_coin (chg_coin),
        .coin_rej (coin_rej),
        .sel_err  (sel_err),
        .vend_done(vend_done),
        .credit   (credit),
        .c_state  (c_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_coin(input logic [1:0] c);
        int val;
        bit rej;
        val = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
        rej = (c == 2'b11) || (c != 2'b00 && (m_state >= 2 || m_credit + val > 40));
        in = c;
        cyc();
        in = 2'b00;
        if (!rej && val > 0) begin
            m_credit += val;
            m_state = 1;
        end
        checks++;
        if (coin_rej !== rej)
            $display("FAIL coin_rej(coin=%0d): got %0b expected %0b", c, coin_rej, rej);
        if (coin_rej !== rej) errors++;
        checks++;
        if (credit !== 6'(m_credit)) begin
            errors++;
            $display("FAIL coin_credit(coin=%0d): got %0d expected %0d", c, credit, m_credit);
        end
    endtask

    task automatic do_select(input int item);
        bit err;
        int price;
        price = (item < 4) ? price_tab[item] : 0;
        err = (m_state != 1) || (item >= 4) || (m_credit < price);
        sel_valid = 1'b1;
        sel_item  = 3'(item);
        cyc();
        sel_valid = 1'b0;
        if (!err) begin
            m_credit -= price;
            m_state = 2;
            m_item  = item;
        end
        checks++;
        if (sel_err !== err || disp_req !== (m_state == 2)) begin
            errors++;
            $display("FAIL select(item=%0d): sel_err=%0b disp_req=%0b expected %0b %0b",
                     item, sel_err, disp_req, err, (m_state == 2));
        end
        checks++;
        if (credit !== 6'(m_credit)) begin
            errors++;
            $display("FAIL select_credit(item=%0d): got %0d expected %0d", item, credit, m_credit);
        end
    endtask

    task automatic finish_dispense(input int delay);
        for (int i = 0; i < delay; i++) begin
            cyc();
            checks++;
            if (disp_req !== 1'b1 || disp_item !== 3'(m_item)) begin
                errors++;
                $display("FAIL disp_hold: req=%0b item=%0d expected 1 %0d", disp_req, disp_item, m_item);
            end
        end
        disp_ack = 1'b1;
        cyc();
        disp_ack = 1'b0;
        m_state = (m_credit > 0) ? 3 : 0;
        checks++;
        if (vend_done !== 1'b1 || disp_req !== 1'b0 || c_state !== 2'(m_state)) begin
            errors++;
            $display("FAIL disp_done: done=%0b req=%0b state=%0d expected 1 0 %0d",
                     vend_done, disp_req, c_state, m_state);
        end
        cyc();
        checks++;
        if (vend_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got %0b expected 0", vend_done);
        end
    endtask

    task automatic collect_change(input int delay);
        int exp_coin;
        while (m_credit > 0) begin
            exp_coin = (m_credit >= 2) ? 2 : 1;
            for (int i = 0; i <= delay; i++) begin
                checks++;
                if (chg_valid !== 1'b1 || chg_coin !== 2'(exp_coin)) begin
                    errors++;
                    $display("FAIL chg_coin: valid=%0b coin=%0d expected 1 %0d",
                             chg_valid, chg_coin, exp_coin);
                end
                if (i < delay) cyc();
            end
            chg_ack = 1'b1;
            cyc();
            chg_ack = 1'b0;
            m_credit -= exp_coin;
            checks++;
            if (credit !== 6'(m_credit)) begin
                errors++;
                $display("FAIL chg_credit: got %0d expected %0d", credit, m_credit);
            end
        end
        m_state = 0;
        checks++;
        if (chg_valid !== 1'b0 || c_state !== 2'd0) begin
            errors++;
            $display("FAIL chg_end: valid=%0b state=%0d expected 0 0", chg_valid, c_state);
        end
    endtask

    task automatic do_cancel;
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        if (m_state == 1) m_state = 3;
        checks++;
        if (c_state !== 2'(m_state) || chg_valid !== (m_state == 3)) begin
            errors++;
            $display("FAIL cancel: state=%0d valid=%0b expected %0d %0b",
                     c_state, chg_valid, m_state, (m_state == 3));
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({disp_req, chg_valid, coin_rej, sel_err, vend_done, disp_item, chg_coin, credit, c_state}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero output while in reset");
        end
        rst = 1'b1;
        cyc();
        checks++;
        if (c_state !== 2'd0 || credit !== 6'd0) begin
            errors++;
            $display("FAIL reset_release: state=%0d credit=%0d expected 0 0", c_state, credit);
        end
        disp_ack = 1'b1;
        chg_ack  = 1'b1;
        cyc();
        disp_ack = 1'b0;
        chg_ack  = 1'b0;
        checks++;
        if (vend_done !== 1'b0 || chg_valid !== 1'b0 || c_state !== 2'd0) begin
            errors++;
            $display("FAIL stray_ack: done=%0b valid=%0b state=%0d expected 0 0 0",
                     vend_done, chg_valid, c_state);
        end
        do_cancel();
        do_select(0);
    endtask

    task automatic test_sel_err_then_vend;
        repeat (3) do_coin(2'b01);
        do_select(1);
        do_coin(2'b01);
        do_select(1);
        finish_dispense(2);
    endtask

    task automatic test_change_after_vend;
        do_coin(2'b10);
        do_coin(2'b10);
        do_coin(2'b01);
        do_select(2);
        finish_dispense(1);
        collect_change(0);
    endtask

    task automatic test_cancel_delayed;
        do_coin(2'b01);
        do_coin(2'b10);
        do_cancel();
        collect_change(4);
    endtask

    task automatic test_coin_reject;
        do_coin(2'b10);
        do_select(3);
        do_coin(2'b01);
        do_coin(2'b10);
        finish_dispense(0);
        do_coin(2'b11);
        repeat (19) do_coin(2'b10);
        do_coin(2'b01);
        do_coin(2'b10);
        do_coin(2'b01);
        do_coin(2'b01);
        do_coin(2'b11);
        do_cancel();
        collect_change(0);
    endtask

    task automatic test_priority;
        do_coin(2'b10);
        in = 2'b01;
        sel_valid = 1'b1;
        sel_item = 3'd3;
        cyc();
        in = 2'b00;
        sel_valid = 1'b0;
        m_credit = 0;
        m_state = 2;
        m_item = 3;
        checks++;
        if (disp_req !== 1'b1 || coin_rej !== 1'b1 || credit !== 6'd0 || disp_item !== 3'd3) begin
            errors++;
            $display("FAIL sel_beats_coin: req=%0b rej=%0b credit=%0d item=%0d expected 1 1 0 3",
                     disp_req, coin_rej, credit, disp_item);
        end
        finish_dispense(0);
        do_coin(2'b01);
        do_select(5);
        do_select(7);
        do_coin(2'b10);
        do_coin(2'b10);
        cancel = 1'b1;
        sel_valid = 1'b1;
        sel_item = 3'd3;
        in = 2'b01;
        cyc();
        cancel = 1'b0;
        sel_valid = 1'b0;
        in = 2'b00;
        m_state = 3;
        checks++;
        if (c_state !== 2'd3 || sel_err !== 1'b0 || disp_req !== 1'b0 || coin_rej !== 1'b1 ||
            credit !== 6'd5) begin
            errors++;
            $display("FAIL cancel_wins: state=%0d err=%0b req=%0b rej=%0b credit=%0d exp 3 0 0 1 5",
                     c_state, sel_err, disp_req, coin_rej, credit);
        end
        collect_change(1);
    endtask

    task automatic test_async_reset;
        do_coin(2'b10);
        do_select(3);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (disp_req !== 1'b0 || c_state !== 2'd0 || credit !== 6'd0) begin
            errors++;
            $display("FAIL rst_dispense: req=%0b state=%0d credit=%0d expected 0 0 0",
                     disp_req, c_state, credit);
        end
        m_credit = 0;
        m_state = 0;
        cyc();
        rst = 1'b1;
        do_coin(2'b10);
        do_coin(2'b01);
        do_cancel();
        #3 rst = 1'b0;
        #1;
        checks++;
        if (chg_valid !== 1'b0 || chg_coin !== 2'd0 || credit !== 6'd0 || c_state !== 2'd0) begin
            errors++;
            $display("FAIL rst_change: valid=%0b coin=%0d credit=%0d state=%0d expected 0 0 0 0",
                     chg_valid, chg_coin, credit, c_state);
        end
        m_credit = 0;
        m_state = 0;
        cyc();
        rst = 1'b1;
        do_coin(2'b10);
        do_select(3);
        finish_dispense(0);
    endtask

    task automatic test_random;
        int action;
        for (int i = 0; i < 80; i++) begin
            action = int'($urandom_range(0, 9));
            if (action < 6) begin
                do_coin(2'($urandom_range(0, 3)));
            end else if (action < 8) begin
                do_select(int'($urandom_range(0, 5)));
                if (m_state == 2) begin
                    finish_dispense(int'($urandom_range(0, 3)));
                    if (m_state == 3) collect_change(int'($urandom_range(0, 3)));
                end
            end else begin
                do_cancel();
                if (m_state == 3) collect_change(int'($urandom_range(0, 2)));
            end
        end
        if (m_state == 1) begin
            do_cancel();
            collect_change(0);
        end
    endtask

    initial begin
        rst = 1'b0;
        in = 2'b00;
        sel_valid = 1'b0;
        sel_item = 3'd0;
        cancel = 1'b0;
        disp_ack = 1'b0;
        chg_ack = 1'b0;
        m_credit = 0;
        m_state = 0;
        m_item = 0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_sel_err_then_vend();
        test_change_after_vend();
        test_cancel_delayed();
        test_coin_reject();
        test_priority();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
